// File: rtl/uart_sender_if.sv
// uart_sender_if: byte-strobe handshake between the UART controller and the
// serial transmitter.
//   TX_EN      controller -> sender  one-cycle start strobe
//   TX_DATA    controller -> sender  byte to send, sampled with an accepted TX_EN
//   UART_TX    sender -> controller  serial line, idles high
//   TX_STATUS  sender -> controller  1 = idle/ready, 0 = frame in progress
interface uart_sender_if;
  logic       TX_EN;
  logic [7:0] TX_DATA;
  logic       UART_TX;
  logic       TX_STATUS;

  modport master (
    output TX_EN,
    output TX_DATA,
    input  UART_TX,
    input  TX_STATUS
  );

  modport slave (
    input  TX_EN,
    input  TX_DATA,
    output UART_TX,
    output TX_STATUS
  );
endinterface

// File: rtl/uart_sender.sv
// uart_sender: serial UART transmitter. A one-cycle TX_EN strobe while idle
// latches TX_DATA and sends one frame: start bit, 8 data bits LSB first,
// optional parity bit, then STOP_BITS stop bits, each bit CLKS_PER_BIT clocks.
// Ports:
//   clk    system clock, all state on posedge
//   reset  asynchronous active-low reset
//   bus    uart_sender_if.slave (TX_EN, TX_DATA in; UART_TX, TX_STATUS out)
// UART_TX and TX_STATUS come straight from flops so the line is glitch-free.
module uart_sender #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  uart_sender_if.slave  bus
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic           PODD      = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        state,    state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_cnt,  bit_nxt;
  logic          stop_cnt, stop_nxt;
  logic [7:0]    shreg,    shreg_nxt;
  logic          par_q,    par_nxt;
  logic          tx_q,     tx_nxt;
  logic          status_q, status_nxt;

  logic baud_last;
  logic stop_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      shreg    <= '0;
      par_q    <= '0;
      tx_q     <= '1;
      status_q <= '1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
      shreg    <= shreg_nxt;
      par_q    <= par_nxt;
      tx_q     <= tx_nxt;
      status_q <= status_nxt;
    end
  end

  // Outputs are computed one cycle ahead (tx_nxt/status_nxt) so that the
  // registered line changes exactly on the bit boundary.
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    stop_nxt   = stop_cnt;
    shreg_nxt  = shreg;
    par_nxt    = par_q;
    tx_nxt     = tx_q;
    status_nxt = status_q;

    baud_last  = (baud_cnt == BAUD_LAST);
    stop_last  = (STOP_BITS == 2) ? stop_cnt : 1'b1;

    case (state)
      ST_IDLE: begin
        tx_nxt     = 1'b1;
        status_nxt = 1'b1;
        if (bus.TX_EN) begin
          shreg_nxt  = bus.TX_DATA;
          par_nxt    = (^bus.TX_DATA) ^ PODD;
          state_nxt  = ST_START;
          baud_nxt   = '0;
          bit_nxt    = '0;
          stop_nxt   = 1'b0;
          tx_nxt     = 1'b0;
          status_nxt = 1'b0;
        end
      end

      ST_START: begin
        if (baud_last) begin
          state_nxt = ST_DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
          shreg_nxt = {1'b0, shreg[7:1]};
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_nxt = ST_PARITY;
              tx_nxt    = par_q;
            end else begin
              state_nxt = ST_STOP;
              stop_nxt  = 1'b0;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            tx_nxt    = shreg[0];
            shreg_nxt = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end

      ST_PARITY: begin
        if (baud_last) begin
          state_nxt = ST_STOP;
          baud_nxt  = '0;
          stop_nxt  = 1'b0;
          tx_nxt    = 1'b1;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end

      ST_STOP: begin
        if (baud_last) begin
          baud_nxt = '0;
          if (stop_last) begin
            state_nxt  = ST_IDLE;
            tx_nxt     = 1'b1;
            status_nxt = 1'b1;
          end else begin
            stop_nxt = stop_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end

      default: begin
        state_nxt  = ST_IDLE;
        tx_nxt     = 1'b1;
        status_nxt = 1'b1;
      end
    endcase
  end

  assign bus.UART_TX   = tx_q;
  assign bus.TX_STATUS = status_q;

endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender: directed bench for uart_sender at CLKS_PER_BIT=4.
// dut0: no parity, 1 stop. dut_e / dut_o: parity enabled (even / odd), 2 stops.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_sender;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic tx_log [0:99];
  logic st_log [0:99];
  logic txe_log [0:59];
  logic ste_log [0:59];
  logic txo_log [0:59];
  logic sto_log [0:59];

  always #5 clk = ~clk;

  uart_sender_if if0 ();
  uart_sender_if ife ();
  uart_sender_if ifo ();

  uart_sender #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  uart_sender #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_e (
    .clk(clk), .reset(reset), .bus(ife)
  );
  uart_sender #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o (
    .clk(clk), .reset(reset), .bus(ifo)
  );

  // Sends d on dut0 and logs ncyc samples; sample i is taken i+1 falling
  // edges after the strobe is raised (sample 0 = first start-bit cycle).
  // Optionally re-strobes at sample inj_at, or on the first idle sample
  // after a busy period (back-to-back).
  task automatic cap0(input logic [7:0] d, input int ncyc, input int inj_at,
                      input logic [7:0] inj_d, input bit b2b, input logic [7:0] b2b_d);
    bit b2b_done = 1'b0;
    bit prev_low = 1'b0;
    @(negedge clk);
    if0.TX_DATA = d;
    if0.TX_EN   = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if0.TX_EN = 1'b0;
      tx_log[i] = if0.UART_TX;
      st_log[i] = if0.TX_STATUS;
      if (i == inj_at) begin
        if0.TX_DATA = inj_d;
        if0.TX_EN   = 1'b1;
      end
      if (b2b && !b2b_done && prev_low && if0.TX_STATUS) begin
        if0.TX_DATA = b2b_d;
        if0.TX_EN   = 1'b1;
        b2b_done    = 1'b1;
      end
      prev_low = !if0.TX_STATUS;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if0.TX_EN   = i[0];
      if0.TX_DATA = 8'h55;
      total++;
      if (if0.UART_TX !== 1'b1 || if0.TX_STATUS !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got tx=%b st=%b want tx=1 st=1", i, if0.UART_TX, if0.TX_STATUS);
      end
    end
    if0.TX_EN = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    if0.TX_DATA = 8'h00;
    if0.TX_EN   = 1'b1;
    @(negedge clk);
    if0.TX_EN = 1'b0;
    @(negedge clk);
    total++;
    if (if0.UART_TX !== 1'b0 || if0.TX_STATUS !== 1'b0) begin
      bad++;
      $display("FAIL reset_prestart got tx=%b st=%b want tx=0 st=0", if0.UART_TX, if0.TX_STATUS);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (if0.UART_TX !== 1'b1 || if0.TX_STATUS !== 1'b1) begin
      bad++;
      $display("FAIL reset_async got tx=%b st=%b want tx=1 st=1", if0.UART_TX, if0.TX_STATUS);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (if0.UART_TX !== 1'b1 || if0.TX_STATUS !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got tx=%b st=%b want tx=1 st=1", if0.UART_TX, if0.TX_STATUS);
    end
  endtask

  task automatic test_basic;
    logic [9:0] exp_a5 = 10'b11_0100_1010;
    int lows = 0;
    cap0(8'hA5, 48, -1, 8'h00, 1'b0, 8'h00);
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 4; k++) begin
        total++;
        if (tx_log[4*b+k] !== exp_a5[b]) begin
          bad++;
          $display("FAIL basic_bit b=%0d k=%0d got %b want %b", b, k, tx_log[4*b+k], exp_a5[b]);
        end
      end
    for (int i = 0; i < 48; i++) if (st_log[i] === 1'b0) lows++;
    total++;
    if (lows != 40) begin
      bad++;
      $display("FAIL basic_status_low got %0d want 40", lows);
    end
    total++;
    if (st_log[0] !== 1'b0 || st_log[39] !== 1'b0 || st_log[40] !== 1'b1) begin
      bad++;
      $display("FAIL basic_status_edges got %b%b%b want 001", st_log[0], st_log[39], st_log[40]);
    end
  endtask

  task automatic test_busy;
    logic [9:0] exp_a5 = 10'b11_0100_1010;
    cap0(8'hA5, 70, 10, 8'h00, 1'b0, 8'h00);
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 4; k++) begin
        total++;
        if (tx_log[4*b+k] !== exp_a5[b]) begin
          bad++;
          $display("FAIL busy_bit b=%0d k=%0d got %b want %b", b, k, tx_log[4*b+k], exp_a5[b]);
        end
      end
    for (int i = 40; i < 70; i++) begin
      total++;
      if (tx_log[i] !== 1'b1 || st_log[i] !== 1'b1) begin
        bad++;
        $display("FAIL busy_no_second i=%0d got tx=%b st=%b want tx=1 st=1", i, tx_log[i], st_log[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_a5 = 10'b11_0100_1010;
    logic [9:0] exp_3c = 10'b10_0111_1000;
    logic [7:0] dec0, dec1;
    int lows = 0;
    cap0(8'hA5, 90, -1, 8'h00, 1'b1, 8'h3C);
    for (int b = 0; b < 10; b++) begin
      total++;
      if (tx_log[4*b+1] !== exp_a5[b]) begin
        bad++;
        $display("FAIL b2b_first b=%0d got %b want %b", b, tx_log[4*b+1], exp_a5[b]);
      end
      total++;
      if (tx_log[41+4*b+1] !== exp_3c[b]) begin
        bad++;
        $display("FAIL b2b_second b=%0d got %b want %b", b, tx_log[41+4*b+1], exp_3c[b]);
      end
    end
    total++;
    if (tx_log[40] !== 1'b1 || st_log[40] !== 1'b1 || tx_log[41] !== 1'b0 || st_log[41] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap got tx=%b%b st=%b%b want tx=10 st=10", tx_log[40], tx_log[41], st_log[40], st_log[41]);
    end
    for (int i = 0; i < 8; i++) begin
      dec0[i] = tx_log[4*(i+1)+2];
      dec1[i] = tx_log[41+4*(i+1)+2];
    end
    total++;
    if (dec0 !== 8'hA5 || dec1 !== 8'h3C) begin
      bad++;
      $display("FAIL b2b_decode got %h %h want a5 3c", dec0, dec1);
    end
    for (int i = 0; i < 90; i++) if (st_log[i] === 1'b0) lows++;
    total++;
    if (lows != 80) begin
      bad++;
      $display("FAIL b2b_status_low got %0d want 80", lows);
    end
  endtask

  task automatic test_parity;
    logic [11:0] exp_e = 12'b1110_0000_1110;
    logic [11:0] exp_o = 12'b1100_0000_1110;
    int lows_e = 0;
    int lows_o = 0;
    @(negedge clk);
    ife.TX_DATA = 8'h07;
    ifo.TX_DATA = 8'h07;
    ife.TX_EN   = 1'b1;
    ifo.TX_EN   = 1'b1;
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      ife.TX_EN  = 1'b0;
      ifo.TX_EN  = 1'b0;
      txe_log[i] = ife.UART_TX;
      ste_log[i] = ife.TX_STATUS;
      txo_log[i] = ifo.UART_TX;
      sto_log[i] = ifo.TX_STATUS;
    end
    for (int b = 0; b < 12; b++)
      for (int k = 0; k < 4; k++) begin
        total++;
        if (txe_log[4*b+k] !== exp_e[b]) begin
          bad++;
          $display("FAIL parity_even_bit b=%0d k=%0d got %b want %b", b, k, txe_log[4*b+k], exp_e[b]);
        end
        total++;
        if (txo_log[4*b+k] !== exp_o[b]) begin
          bad++;
          $display("FAIL parity_odd_bit b=%0d k=%0d got %b want %b", b, k, txo_log[4*b+k], exp_o[b]);
        end
      end
    for (int i = 0; i < 56; i++) begin
      if (ste_log[i] === 1'b0) lows_e++;
      if (sto_log[i] === 1'b0) lows_o++;
    end
    total++;
    if (lows_e != 48 || lows_o != 48) begin
      bad++;
      $display("FAIL parity_status_low got %0d/%0d want 48/48", lows_e, lows_o);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] exp_3c = 10'b10_0111_1000;
    @(negedge clk);
    if0.TX_DATA = 8'hFF;
    if0.TX_EN   = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if0.TX_EN = 1'b0;
    end
    total++;
    if (if0.TX_STATUS !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy got st=%b want 0", if0.TX_STATUS);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (if0.UART_TX !== 1'b1 || if0.TX_STATUS !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset got tx=%b st=%b want tx=1 st=1", if0.UART_TX, if0.TX_STATUS);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (if0.UART_TX !== 1'b1 || if0.TX_STATUS !== 1'b1) begin
        bad++;
        $display("FAIL mid_no_resume i=%0d got tx=%b st=%b want tx=1 st=1", i, if0.UART_TX, if0.TX_STATUS);
      end
    end
    cap0(8'h3C, 44, -1, 8'h00, 1'b0, 8'h00);
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 4; k++) begin
        total++;
        if (tx_log[4*b+k] !== exp_3c[b]) begin
          bad++;
          $display("FAIL mid_after_bit b=%0d k=%0d got %b want %b", b, k, tx_log[4*b+k], exp_3c[b]);
        end
      end
    total++;
    if (st_log[39] !== 1'b0 || st_log[40] !== 1'b1) begin
      bad++;
      $display("FAIL mid_after_status got %b%b want 01", st_log[39], st_log[40]);
    end
  endtask

  initial begin
    reset       = 1'b0;
    if0.TX_EN   = 1'b0;
    if0.TX_DATA = 8'h00;
    ife.TX_EN   = 1'b0;
    ife.TX_DATA = 8'h00;
    ifo.TX_EN   = 1'b0;
    ifo.TX_DATA = 8'h00;
    test_reset;
    test_basic;
    repeat (3) @(negedge clk);
    test_busy;
    repeat (3) @(negedge clk);
    test_back_to_back;
    repeat (3) @(negedge clk);
    test_parity;
    repeat (3) @(negedge clk);
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
